// File: rtl/apple_iie_dram_array.sv
`default_nettype none
// ============================================================================
// Module  : apple_iie_dram_array
// Brief   : Main/aux 64K x 8 DRAM bank model on the multiplexed RA bus,
//           with RAS-only refresh counting and protocol-error flagging.
// Revision: 1.0
// ============================================================================
module apple_iie_dram_array #(
  parameter int ADDR_BITS = 16,
  parameter int READ_LAT  = 2
) (
  input  logic        clk_14m,
  input  logic        reset_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic [7:0]  ra,
  input  logic        ramen_n,
  input  logic        en80_n,
  input  logic        rw_n,
  input  logic [7:0]  md_in,
  output logic [7:0]  md_out,
  output logic        md_oe,
  output logic [15:0] refresh_cnt,
  output logic        proto_err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROW    = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t           state_q;
  logic             ras_q;
  logic             cas_q;
  logic [7:0]       row_q;
  logic [7:0]       col_q;
  logic             rw_q;
  logic [7:0]       wdata_q;
  logic             sel_main_q;
  logic             sel_aux_q;
  logic             conflict_q;
  logic             cas_seen_q;
  logic [LAT_W-1:0] lat_q;
  logic [7:0]       md_out_q;
  logic             md_oe_q;
  logic [15:0]      refresh_q;
  logic             proto_err_q;

  logic [7:0] mem_main_q [0:DEPTH-1];
  logic [7:0] mem_aux_q  [0:DEPTH-1];

  logic                 ras_fall_d;
  logic                 ras_rise_d;
  logic                 cas_fall_d;
  logic                 cas_rise_d;
  logic [15:0]          cell_full_d;
  logic [ADDR_BITS-1:0] idx_d;
  logic [7:0]           rdata_d;
  logic                 commit_d;

  assign ras_fall_d  = ras_q & ~ras_n;
  assign ras_rise_d  = ~ras_q & ras_n;
  assign cas_fall_d  = cas_q & ~cas_n;
  assign cas_rise_d  = ~cas_q & cas_n;
  assign cell_full_d = {col_q, row_q};
  assign idx_d       = cell_full_d[ADDR_BITS-1:0];
  assign rdata_d     = sel_aux_q ? mem_aux_q[idx_d] : mem_main_q[idx_d];

  // A write lands on the first ACCESS cycle unless the strobes already released.
  assign commit_d = (state_q == S_ACCESS) && (lat_q == '0) && !rw_q &&
                    !ras_rise_d && !cas_rise_d;

  always_ff @(posedge clk_14m) begin
    if (commit_d && sel_main_q) mem_main_q[idx_d] <= wdata_q;
    if (commit_d && sel_aux_q)  mem_aux_q[idx_d]  <= wdata_q;
  end

  always_ff @(posedge clk_14m or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ras_q       <= 1'b1;
      cas_q       <= 1'b1;
      row_q       <= 8'h00;
      col_q       <= 8'h00;
      rw_q        <= 1'b1;
      wdata_q     <= 8'h00;
      sel_main_q  <= 1'b0;
      sel_aux_q   <= 1'b0;
      conflict_q  <= 1'b0;
      cas_seen_q  <= 1'b0;
      lat_q       <= '0;
      md_out_q    <= 8'h00;
      md_oe_q     <= 1'b0;
      refresh_q   <= 16'h0000;
      proto_err_q <= 1'b0;
    end else begin
      ras_q <= ras_n;
      cas_q <= cas_n;
      case (state_q)
        S_IDLE: begin
          if (ras_fall_d && cas_fall_d) begin
            row_q       <= ra;
            proto_err_q <= 1'b1;
          end else if (cas_fall_d) begin
            proto_err_q <= 1'b1;
          end else if (ras_fall_d) begin
            row_q      <= ra;
            cas_seen_q <= 1'b0;
            state_q    <= S_ROW;
          end
        end
        S_ROW: begin
          if (ras_rise_d) begin
            // Only a RAS cycle with no CAS at all counts as a refresh.
            if (!cas_seen_q) refresh_q <= refresh_q + 16'd1;
            state_q <= S_IDLE;
          end else if (cas_fall_d) begin
            col_q      <= ra;
            rw_q       <= rw_n;
            wdata_q    <= md_in;
            sel_main_q <= ~ramen_n & en80_n;
            sel_aux_q  <= ramen_n & ~en80_n;
            conflict_q <= ~ramen_n & ~en80_n;
            cas_seen_q <= 1'b1;
            lat_q      <= '0;
            state_q    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (ras_rise_d) begin
            state_q <= S_IDLE;
          end else if (cas_rise_d) begin
            state_q <= S_ROW;
          end else begin
            if (conflict_q) proto_err_q <= 1'b1;
            if (!rw_q || !(sel_main_q || sel_aux_q)) begin
              state_q <= S_HOLD;
            end else if (lat_q == LAT_LAST) begin
              md_out_q <= rdata_d;
              md_oe_q  <= 1'b1;
              state_q  <= S_HOLD;
            end else begin
              lat_q <= lat_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (ras_rise_d) begin
            md_oe_q <= 1'b0;
            state_q <= S_IDLE;
          end else if (cas_rise_d) begin
            md_oe_q <= 1'b0;
            state_q <= S_ROW;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md_out      = md_out_q;
  assign md_oe       = md_oe_q;
  assign refresh_cnt = refresh_q;
  assign proto_err   = proto_err_q;

endmodule
`default_nettype wire
